// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl
// Issue/return controller that sits in front of a fixed-latency c_addsub
// core. It registers each accepted operand pair onto the core inputs. It
// tracks every pair through the core with a valid-tag shift register. It
// then captures the core result into a first-word-fall-through buffer.
// Credit-based flow control keeps the buffer from overflowing. Because of
// that, the core never has to stall.
//
// Ports
//   CLK, RST             clock (rising edge), synchronous active-high reset
//   IN_VALID/IN_READY    operand pair handshake
//   IN_A, IN_B, IN_ADD   operands and mode (1=add, 0=A-B)
//   IP_A, IP_B, IP_ADD   registered operands/mode driven to the core
//   IP_S                 core result, meaningful only when a tag exits
//   OUT_VALID/OUT_READY  result handshake
//   OUT_S                result at buffer head
//   BUSY                 any pair in flight or buffered
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its data stable until that
// edge. IN_READY and OUT_VALID depend only on registered state (and RST),
// never on IN_VALID or OUT_READY.

module addsub_issue_ctrl #(
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic             IN_ADD,
  output logic [WIDTH-1:0] IP_A,
  output logic [WIDTH-1:0] IP_B,
  output logic             IP_ADD,
  input  logic [WIDTH-1:0] IP_S,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_S,
  output logic             BUSY
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  // tag[0] is set on the accept edge. tag[LATENCY] marks the edge on which
  // the core result for that pair is present on IP_S.
  logic [LATENCY:0]  tag;
  logic [CW-1:0]     credit;
  logic [CW-1:0]     fifo_cnt;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [WIDTH-1:0]  mem [FIFO_DEPTH];

  logic accept;
  logic pop;
  logic wr;
  logic fifo_full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count every pair not yet popped, whether it is in flight or
  // buffered. Therefore the buffer always has room for every tag that can
  // exit.
  assign IN_READY  = !RST && (credit < CW'(FIFO_DEPTH));
  assign OUT_VALID = (fifo_cnt != '0);
  assign OUT_S     = OUT_VALID ? mem[rd_ptr] : '0;
  assign BUSY      = (credit != '0);
  assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));

  assign accept = IN_VALID && IN_READY;
  assign pop    = OUT_VALID && OUT_READY;
  assign wr     = tag[LATENCY];

  // Operand registers feeding the core
  always_ff @(posedge CLK) begin
    if (RST) begin
      IP_A   <= '0;
      IP_B   <= '0;
      IP_ADD <= 1'b1;
    end else if (accept) begin
      IP_A   <= IN_A;
      IP_B   <= IN_B;
      IP_ADD <= IN_ADD;
    end
  end

  // Tag pipeline and credit counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag    <= '0;
      credit <= '0;
    end else begin
      tag <= {tag[LATENCY-1:0], accept};
      case ({accept, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  // Buffer pointers and occupancy. A write and a pop on the same edge while
  // full is safe: the head is read before the edge and overwritten on it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr)  wr_ptr <= next_ptr(wr_ptr);
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset; OUT_S is gated by OUT_VALID.
  always_ff @(posedge CLK) begin
    if (wr && !RST) mem[wr_ptr] <= IP_S;
  end

  // The credit scheme must make these impossible.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(wr && fifo_full && !pop));
      assert (credit <= CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
module tb_addsub_issue_ctrl;
  localparam int W = 32;
  localparam int L = 2;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] IN_A;
  logic [W-1:0] IN_B;
  logic         IN_ADD;
  logic [W-1:0] IP_A;
  logic [W-1:0] IP_B;
  logic         IP_ADD;
  logic [W-1:0] IP_S;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] OUT_S;
  logic         BUSY;

  addsub_issue_ctrl #(.WIDTH(W), .LATENCY(L), .FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_ADD(IN_ADD),
    .IP_A(IP_A), .IP_B(IP_B), .IP_ADD(IP_ADD), .IP_S(IP_S),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_S(OUT_S),
    .BUSY(BUSY)
  );

  // clock
  always #5 CLK = ~CLK;

  // c_addsub core model: L-edge pipeline
  logic [W-1:0] core_pipe [L];
  always @(posedge CLK) begin
    core_pipe[0] <= IP_ADD ? (IP_A + IP_B) : (IP_A - IP_B);
    for (int i = 1; i < L; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign IP_S = core_pipe[L-1];

  // reference model: every accepted, not-yet-popped pair with the edge
  // number from which its result may be seen
  logic [W-1:0] exp_q[$];
  int           rdy_q[$];
  int           edge_cnt = 0;
  logic [W-1:0] m_ip_a   = '0;
  logic [W-1:0] m_ip_b   = '0;
  logic         m_ip_add = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // one clock cycle: drive, check outputs, advance the model across the edge
  task automatic step(input logic rst, input logic iv, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic add, input logic ordy,
                      output logic acc);
    logic exp_rdy;
    logic exp_ov;
    logic do_pop;
    RST = rst; IN_VALID = iv; IN_A = a; IN_B = b; IN_ADD = add; OUT_READY = ordy;
    #1;
    exp_rdy = !rst && (exp_q.size() < D);
    exp_ov  = (exp_q.size() > 0) && (rdy_q[0] <= edge_cnt);
    check("in_ready", W'(IN_READY), W'(exp_rdy));
    check("busy", W'(BUSY), W'(exp_q.size() != 0));
    check("out_valid", W'(OUT_VALID), W'(exp_ov));
    if (exp_ov) check("out_s", OUT_S, exp_q[0]);
    check("ip_a", IP_A, m_ip_a);
    check("ip_b", IP_B, m_ip_b);
    check("ip_add", W'(IP_ADD), W'(m_ip_add));
    acc    = iv && exp_rdy;
    do_pop = exp_ov && ordy && !rst;
    @(posedge CLK);
    edge_cnt++;
    if (rst) begin
      exp_q.delete(); rdy_q.delete();
      m_ip_a = '0; m_ip_b = '0; m_ip_add = 1'b1;
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front()); void'(rdy_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(add ? a + b : a - b);
        rdy_q.push_back(edge_cnt + L + 1);
        m_ip_a = a; m_ip_b = b; m_ip_add = add;
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1, ordy, acc);
  endtask

  initial begin
    logic         acc;
    logic [W-1:0] pa, pb;
    logic         padd;
    int           k;

    RST = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_ADD = 1'b1; OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_out_s", OUT_S, '0);
    check("rst_ip_add", W'(IP_ADD), W'(1));
    @(negedge CLK);

    // reset held: IN_READY must be low
    step(1'b1, 1'b1, 32'd9, 32'd9, 1'b1, 1'b1, acc);
    idle(1, 1'b1);

    // basic add and latency
    step(1'b0, 1'b1, 32'd3, 32'd2, 1'b1, 1'b1, acc);
    idle(6, 1'b1);

    // subtract borrow and add wrap
    step(1'b0, 1'b1, 32'd3, 32'd5, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, acc);
    idle(6, 1'b1);

    // back-pressure: five pairs offered, consumer stalled for 10 cycles
    k = 1;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, k <= 5, W'(k), W'(k), 1'b1, c >= 10, acc);
      if (acc) k++;
    end

    // fill buffer, then stream with consumer always ready
    for (int c = 0; c < 50; c++) begin
      pa = $urandom; pb = $urandom; padd = 1'($urandom_range(0, 1));
      step(1'b0, 1'b1, pa, pb, padd, c >= 8, acc);
    end
    idle(8, 1'b1);

    // reset with two pairs in flight
    step(1'b0, 1'b1, 32'd11, 32'd12, 1'b1, 1'b1, acc);
    step(1'b0, 1'b1, 32'd13, 32'd14, 1'b0, 1'b1, acc);
    step(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, acc);
    #1;
    check("post_rst_out_s", OUT_S, '0);
    idle(6, 1'b1);
    step(1'b0, 1'b1, 32'd7, 32'd1, 1'b1, 1'b1, acc);
    idle(6, 1'b1);

    // random traffic with occasional resets; a pair is held until taken
    pa = $urandom; pb = $urandom; padd = 1'($urandom_range(0, 1));
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, pa, pb, padd,
           $urandom_range(0, 3) != 0, acc);
      if (acc) begin
        pa = $urandom; pb = $urandom; padd = 1'($urandom_range(0, 1));
      end
    end
    idle(10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_issue_ctrl.md
ADDSUB_ISSUE_CTRL -- requirements
Module: addsub_issue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter LATENCY, default 2, pipeline depth of the attached c_addsub core in clock edges (legal 1..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (legal 2..16).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named CLK and RST.
REQ-005 Port: CLK  in  1  clock, all state on rising edge.
REQ-006 Port: RST  in  1  synchronous active-high reset.
REQ-007 Port: IN_VALID  in  1  operand pair offered.
REQ-008 Port: IN_READY  out  1  block can accept pair this cycle.
REQ-009 Port: IN_A, IN_B  in  WIDTH  operands.
REQ-010 Port: IN_ADD  in  1  1=add, 0=subtract (A-B).
REQ-011 Port: IP_A, IP_B  out  WIDTH  registered operands to core A/B.
REQ-012 Port: IP_ADD  out  1  registered mode to core ADD.
REQ-013 Port: IP_S  in  WIDTH  core result S.
REQ-014 Port: OUT_VALID  out  1  result available.
REQ-015 Port: OUT_READY  in  1  consumer takes result.
REQ-016 Port: OUT_S  out  WIDTH  result at FIFO head.
REQ-017 Port: BUSY  out  1  any pair in flight or buffered.

Function
REQ-018 Accept SHALL occur on a rising edge where IN_VALID && IN_READY; IP_A/IP_B/IP_ADD load IN_A/IN_B/IN_ADD on that edge, otherwise hold.
REQ-019 A LATENCY+1-stage valid-tag shift register SHALL track each accepted pair; the tag for a pair accepted at edge k exits at edge k+LATENCY+1, writing IP_S into the FIFO at that edge.
REQ-020 OUT_VALID for a pair accepted at edge k SHALL first be high in the cycle after edge k+LATENCY+1 when the FIFO was empty.
REQ-021 FIFO SHALL be first-word-fall-through: OUT_S = head entry whenever OUT_VALID=1; pop on edge with OUT_VALID && OUT_READY.
REQ-022 OUT_VALID and OUT_S SHALL remain stable until popped; results SHALL leave in accept order.
REQ-023 Credit count C = tags in flight + FIFO occupancy; IN_READY = (C < FIFO_DEPTH), registered-state only, no combinational path from OUT_READY or IN_VALID.
REQ-024 Same-edge accept and pop SHALL leave C unchanged; same-edge FIFO write and pop with FIFO full SHALL be legal and lose nothing.
REQ-025 FIFO write SHALL never find FIFO full without same-edge pop (guaranteed by REQ-023); an assertion SHALL flag violation.
REQ-026 Block SHALL not alter data: arithmetic (modulo 2^WIDTH wrap, borrow) is entirely the core's.
REQ-027 BUSY = (C != 0).
REQ-028 Core output while no tag exits SHALL be ignored.

Reset
REQ-029 On RST edge: tags cleared, FIFO emptied, C=0; IP_A=0, IP_B=0, IP_ADD=1, OUT_VALID=0, OUT_S=0, IN_READY=1, BUSY=0 from next cycle.
REQ-030 RST SHALL override a same-edge accept, pop or FIFO write; pairs in flight at reset SHALL never appear at OUT_S.
REQ-031 IN_READY SHALL be 0 while RST is high.

Verification (WIDTH=32, LATENCY=2, FIFO_DEPTH=4, bench core model: S = ADD ? A+B : A-B, LATENCY edges)
REQ-032 Accept A=3,B=2,ADD=1 at edge 0, OUT_READY=1 -> OUT_VALID=1, OUT_S=5 in cycle after edge 3, cleared after pop; BUSY 0 afterward.
REQ-033 A=3,B=5,ADD=0 -> OUT_S=0xFFFFFFFE; A=0xFFFFFFFF,B=1,ADD=1 -> OUT_S=0x00000000.
REQ-034 OUT_READY=0, IN_VALID held with pairs (1,1),(2,2),(3,3),(4,4),(5,5) -> IN_READY=0 after 4th accept, 5th held; OUT_READY=1 -> outputs 2,4,6,8,10 in order, no loss.
REQ-035 Full FIFO, OUT_READY=1 and IN_VALID=1 continuous -> steady state with no gaps lost, C never exceeds 4, FIFO-full assertion never fires.
REQ-036 Two pairs in flight, RST pulsed one cycle -> OUT_VALID=0, BUSY=0, IN_READY=1 after reset; no stale result ever appears; next pair 7+1 returns OUT_S=8 at normal latency.
